// File: rtl/aes_pkg.sv
// Shared AES types: byte/word/state typedefs and the S-box sharing FSM encoding.
package aes_pkg;

    typedef logic [7:0]   byte_t;
    typedef logic [31:0]  word_t;
    typedef logic [127:0] state_t;

    typedef enum logic [1:0] {
        IDLE,
        ST_RUN,
        KEY_RUN
    } sbox_fsm_e;

    localparam int unsigned AES_STATE_BYTES = 16;

endpackage

// File: rtl/sbox.sv
// AES forward S-box, combinational: GF(2^8) inverse (x^254) followed by the affine map.
module sbox
    import aes_pkg::*;
(
    input  byte_t x,
    output byte_t y
);

    function automatic byte_t gmul(input byte_t a, input byte_t b);
        byte_t p;
        byte_t aa;
        byte_t bb;
        p  = '0;
        aa = a;
        bb = b;
        for (int unsigned i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0 as the S-box requires
    function automatic byte_t ginv(input byte_t a);
        byte_t r;
        byte_t sq;
        r  = 8'h01;
        sq = a;
        for (int unsigned i = 1; i < 8; i++) begin
            sq = gmul(sq, sq);
            r  = gmul(r, sq);
        end
        return r;
    endfunction

    byte_t b;

    always_comb begin
        b = ginv(x);
        y = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
              ^ {b[3:0], b[7:4]} ^ 8'h63;
    end

endmodule

// File: rtl/sbox_share_arb.sv
// Grant and ready generation for the shared S-box bank.
// SBOX_SHARE_RR_EN selects round-robin; otherwise key has fixed priority over st.
module sbox_share_arb (
`ifdef SBOX_SHARE_RR_EN
    input  logic clk,
    input  logic rst_n,
`endif
    input  logic idle,
    input  logic st_valid,
    input  logic key_valid,
    output logic st_ready,
    output logic key_ready
);

    logic grant_key;

`ifdef SBOX_SHARE_RR_EN
    logic last_key;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_key <= 1'b0;
        end else if (st_valid && st_ready) begin
            last_key <= 1'b0;
        end else if (key_valid && key_ready) begin
            last_key <= 1'b1;
        end
    end

    assign grant_key = key_valid && (!st_valid || !last_key);
`else
    assign grant_key = key_valid;
`endif

    assign key_ready = idle && grant_key;
    assign st_ready  = idle && st_valid && !grant_key;

endmodule

// File: rtl/sbox_share_ctrl.sv
// Time-shares LANES S-boxes between SubBytes (128-bit state) and SubWord (32-bit word).
// Optional macro SBOX_SHARE_RR_EN: round-robin arbitration instead of key-over-st priority.
module sbox_share_ctrl
    import aes_pkg::*;
#(
    parameter int unsigned LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         st_valid,
    output logic         st_ready,
    input  logic [127:0] st_data,
    output logic         st_done,
    output logic [127:0] st_result,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [31:0]  key_word,
    output logic         key_done,
    output logic [31:0]  key_result,
    output logic         busy
);

    localparam int unsigned ST_BEATS  = AES_STATE_BYTES / LANES;
    localparam int unsigned KEY_BEATS = 4 / LANES;
    localparam logic [3:0]  ST_LAST   = 4'(ST_BEATS - 1);
    localparam logic [3:0]  KEY_LAST  = 4'(KEY_BEATS - 1);

    sbox_fsm_e  state, state_nx;
    logic [3:0] cnt;
    state_t     opnd, acc, acc_nx;
    byte_t      lane_in  [LANES];
    byte_t      lane_out [LANES];
    logic       st_acc, key_acc, st_last, key_last;

    assign st_acc   = st_valid && st_ready;
    assign key_acc  = key_valid && key_ready;
    assign st_last  = (state == ST_RUN) && (cnt == ST_LAST);
    assign key_last = (state == KEY_RUN) && (cnt == KEY_LAST);

    sbox_share_arb u_arb (
`ifdef SBOX_SHARE_RR_EN
        .clk       (clk),
        .rst_n     (rst_n),
`endif
        .idle      (state == IDLE),
        .st_valid  (st_valid),
        .key_valid (key_valid),
        .st_ready  (st_ready),
        .key_ready (key_ready)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (key_acc)     state_nx = KEY_RUN;
                else if (st_acc) state_nx = ST_RUN;
            end
            ST_RUN:  if (st_last)  state_nx = IDLE;
            KEY_RUN: if (key_last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    // Beat cnt selects operand bytes cnt*LANES.. and writes results back to the same bytes
    always_comb begin : lane_mux
        int unsigned base;
        base   = 32'(cnt) * LANES;
        acc_nx = acc;
        for (int unsigned i = 0; i < LANES; i++) begin
            lane_in[i]                  = opnd[(base + i) * 8 +: 8];
            acc_nx[(base + i) * 8 +: 8] = lane_out[i];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        sbox u_sbox (
            .x (lane_in[g]),
            .y (lane_out[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            opnd       <= '0;
            acc        <= '0;
            st_result  <= '0;
            key_result <= '0;
            st_done    <= 1'b0;
            key_done   <= 1'b0;
        end else begin
            st_done  <= 1'b0;
            key_done <= 1'b0;
            if (state == IDLE) begin
                if (key_acc) begin
                    opnd <= {96'h0, key_word};
                    cnt  <= '0;
                    acc  <= '0;
                end else if (st_acc) begin
                    opnd <= st_data;
                    cnt  <= '0;
                    acc  <= '0;
                end
            end else begin
                acc <= acc_nx;
                cnt <= cnt + 4'd1;
                if (st_last) begin
                    st_result <= acc_nx;
                    st_done   <= 1'b1;
                end
                if (key_last) begin
                    key_result <= acc_nx[31:0];
                    key_done   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sbox_share_ctrl.sv
// Directed self-checking bench: LANES=4 instance plus a LANES=1 instance.
module tb_sbox_share_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         st_valid, st_ready, st_done, key_valid, key_ready, key_done, busy;
    logic [127:0] st_data, st_result;
    logic [31:0]  key_word, key_result;
    logic         st_valid1, st_ready1, st_done1, key_valid1, key_ready1, key_done1, busy1;
    logic [127:0] st_data1, st_result1;
    logic [31:0]  key_word1, key_result1;

    int checks = 0;
    int errors = 0;
    int lat;
    int ndone;
    logic seen;

    localparam logic [127:0] ALL63 = {16{8'h63}};
    localparam logic [127:0] COL_IN = {104'h0, 24'hff0153};
    localparam logic [127:0] COL_OUT = {{13{8'h63}}, 24'h167ced};

    always #5 clk = ~clk;

    sbox_share_ctrl #(.LANES(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid), .st_ready(st_ready), .st_data(st_data),
        .st_done(st_done), .st_result(st_result),
        .key_valid(key_valid), .key_ready(key_ready), .key_word(key_word),
        .key_done(key_done), .key_result(key_result), .busy(busy)
    );

    sbox_share_ctrl #(.LANES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid1), .st_ready(st_ready1), .st_data(st_data1),
        .st_done(st_done1), .st_result(st_result1),
        .key_valid(key_valid1), .key_ready(key_ready1), .key_word(key_word1),
        .key_done(key_done1), .key_result(key_result1), .busy(busy1)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Returns the index of the first negedge (1 = just after the accept edge) showing done
    task automatic wait_done(input int sel, input int budget, output int n_out);
        logic d;
        n_out = -1;
        for (int n = 1; n <= budget; n++) begin
            @(negedge clk);
            case (sel)
                0:       d = st_done;
                1:       d = key_done;
                2:       d = st_done1;
                default: d = key_done1;
            endcase
            if (d) begin
                n_out = n;
                break;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        st_valid = 0; key_valid = 0; st_data = '0; key_word = '0;
        st_valid1 = 0; key_valid1 = 0; st_data1 = '0; key_word1 = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_st_result", st_result, '0);
        check("rst_key_result", {96'h0, key_result}, '0);
        check("rst_busy", {127'h0, busy}, 128'h0);
        check("rst_st_done", {127'h0, st_done}, 128'h0);
        check("rst_busy1", {127'h0, busy1}, 128'h0);

        // All-zero state
        st_valid = 1; st_data = '0;
        #1 check("zero_st_ready", {127'h0, st_ready}, 128'h1);
        check("zero_key_ready", {127'h0, key_ready}, 128'h0);
        @(posedge clk); #1 st_valid = 0; st_data = '1;
        wait_done(0, 40, lat);
        check("zero_lat", 128'(lat), 128'd5);
        check("zero_result", st_result, ALL63);
        check("zero_key_untouched", {96'h0, key_result}, '0);
        @(negedge clk);
        check("zero_done_pulse", {127'h0, st_done}, 128'h0);
        check("zero_idle", {127'h0, busy}, 128'h0);

        // SubWord
        key_valid = 1; key_word = 32'hcf4f3c09;
        #1 check("key_ready", {127'h0, key_ready}, 128'h1);
        @(posedge clk); #1 key_valid = 0; key_word = 32'h0;
        check("key_busy", {127'h0, busy}, 128'h1);
        wait_done(1, 40, lat);
        check("key_lat", 128'(lat), 128'd2);
        check("key_result", {96'h0, key_result}, {96'h0, 32'h8a84eb01});
        check("key_st_untouched", st_result, ALL63);
        @(negedge clk);
        check("key_done_pulse", {127'h0, key_done}, 128'h0);

        // Collision: both valid in IDLE
        st_valid = 1; st_data = COL_IN;
        key_valid = 1; key_word = 32'h00000053;
        #1;
`ifdef SBOX_SHARE_RR_EN
        check("col_st_ready", {127'h0, st_ready}, 128'h1);
        check("col_key_ready", {127'h0, key_ready}, 128'h0);
        @(posedge clk); #1 st_valid = 0;
        seen = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            check("col_key_not_first", {127'h0, key_done}, 128'h0);
            if (st_done) begin
                seen = 1;
                break;
            end
            check("col_key_blocked", {127'h0, key_ready}, 128'h0);
        end
        check("col_st_seen", {127'h0, seen}, 128'h1);
        check("col_st_result", st_result, COL_OUT);
        check("col_key_ready2", {127'h0, key_ready}, 128'h1);
        @(posedge clk); #1 key_valid = 0;
        wait_done(1, 40, lat);
        check("col_key_lat", 128'(lat), 128'd2);
        check("col_key_result", {96'h0, key_result}, {96'h0, 32'h636363ed});
`else
        check("col_key_ready", {127'h0, key_ready}, 128'h1);
        check("col_st_ready", {127'h0, st_ready}, 128'h0);
        @(posedge clk); #1 key_valid = 0;
        seen = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            check("col_st_not_first", {127'h0, st_done}, 128'h0);
            if (key_done) begin
                seen = 1;
                break;
            end
            check("col_st_blocked", {127'h0, st_ready}, 128'h0);
        end
        check("col_key_seen", {127'h0, seen}, 128'h1);
        check("col_key_result", {96'h0, key_result}, {96'h0, 32'h636363ed});
        check("col_st_ready2", {127'h0, st_ready}, 128'h1);
        @(posedge clk); #1 st_valid = 0;
        wait_done(0, 40, lat);
        check("col_st_lat", 128'(lat), 128'd5);
        check("col_st_result", st_result, COL_OUT);
`endif
        @(negedge clk);

        // Reset during beat 2 of ST_RUN
        st_valid = 1; st_data = COL_IN;
        @(posedge clk); #1 st_valid = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #2;
        check("mrst_busy", {127'h0, busy}, 128'h0);
        check("mrst_st_result", st_result, '0);
        check("mrst_key_result", {96'h0, key_result}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (st_done) ndone++;
        end
        check("mrst_no_done", 128'(ndone), 128'd0);
        st_valid = 1; st_data = '0;
        @(posedge clk); #1 st_valid = 0;
        wait_done(0, 40, lat);
        check("mrst_next_lat", 128'(lat), 128'd5);
        check("mrst_next_result", st_result, ALL63);
        @(negedge clk);

        // LANES=1 instance: state request
        st_valid1 = 1; st_data1 = COL_IN;
        #1 check("l1_st_ready", {127'h0, st_ready1}, 128'h1);
        @(posedge clk); #1 st_valid1 = 0;
        wait_done(2, 60, lat);
        check("l1_st_lat", 128'(lat), 128'd17);
        check("l1_st_result", st_result1, COL_OUT);
        @(negedge clk);

        // LANES=1: back-to-back key requests, second accepted on the done cycle
        key_valid1 = 1; key_word1 = 32'hcf4f3c09;
        @(posedge clk); #1 key_word1 = 32'h0;
        wait_done(3, 40, lat);
        check("l1_key1_lat", 128'(lat), 128'd5);
        check("l1_key1_result", {96'h0, key_result1}, {96'h0, 32'h8a84eb01});
        check("l1_key_ready_on_done", {127'h0, key_ready1}, 128'h1);
        @(posedge clk); #1 key_valid1 = 0;
        wait_done(3, 40, lat);
        check("l1_key2_lat", 128'(lat), 128'd5);
        check("l1_key2_result", {96'h0, key_result1}, {96'h0, 32'h63636363});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
